// File: rtl/fir_pkg.sv
// Shared defaults, sample type and phase encoding for the decimating FIR output stage.
package fir_pkg;

  localparam int DEF_IN_WIDTH  = 19;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_DECIM     = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_WARMUP    = 12;

  typedef logic [DEF_OUT_WIDTH-1:0] sample_t;

  typedef enum logic {
    PH_WARMUP = 1'b0,
    PH_RUN    = 1'b1
  } phase_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_decim_fifo_if.sv
// Valid/ready sample stream delivered by the decimating FIR output stage.
interface fir_decim_fifo_if;
  import fir_pkg::*;

  sample_t m_data;
  logic    m_valid;
  logic    m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fir_sfifo.sv
// Synchronous FIFO with an exact occupancy counter; a pop frees the slot a same-cycle push may use.
module fir_sfifo
  import fir_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == {(AW+1){1'b0}});
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage and pointers; power-of-two depth makes the pointer wrap free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= {(AW+1){1'b0}};
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/fir_decim_fifo.sv
// Discards filter warm-up results, keeps one of every DECIM words, clamps it and queues it
// for a valid/ready consumer, tracking dropped samples and clamp events.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int DECIM     = DEF_DECIM,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WARMUP    = DEF_WARMUP
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      fir_data,
  fir_decim_fifo_if.master         m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_cnt,
  output logic                     sat_flag,
  input  logic                     clr_stat
);

  localparam int WCW = cnt_width(WARMUP + 1);
  localparam int DCW = cnt_width(DECIM);
  localparam int LW  = $clog2(DEPTH) + 1;

  phase_t               r_phase;
  phase_t               w_phase_nxt;
  logic [WCW-1:0]       r_warm_cnt;
  logic [DCW-1:0]       r_dec_cnt;
  logic                 w_strobe;
  logic                 w_over;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [OUT_WIDTH-1:0] w_sample;
  logic [OUT_WIDTH-1:0] w_fifo_data;
  logic [LW-1:0]        w_level;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_WARMUP;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Leave warm-up after the WARMUP-th input word; only a reset returns here.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_WARMUP: begin
        if (r_warm_cnt == WCW'(WARMUP - 1)) begin
          w_phase_nxt = PH_RUN;
        end else begin
          w_phase_nxt = PH_WARMUP;
        end
      end
      PH_RUN:  w_phase_nxt = PH_RUN;
      default: w_phase_nxt = PH_WARMUP;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_warm_cnt <= {WCW{1'b0}};
    end else if (r_phase == PH_WARMUP) begin
      r_warm_cnt <= r_warm_cnt + WCW'(1);
    end else begin
      r_warm_cnt <= r_warm_cnt;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_dec_cnt <= {DCW{1'b0}};
    end else if (w_strobe) begin
      r_dec_cnt <= {DCW{1'b0}};
    end else if (r_phase == PH_RUN) begin
      r_dec_cnt <= r_dec_cnt + DCW'(1);
    end else begin
      r_dec_cnt <= r_dec_cnt;
    end
  end

  assign w_strobe = (r_phase == PH_RUN) && (r_dec_cnt == DCW'(DECIM - 1));
  assign w_over   = |fir_data[IN_WIDTH-1:OUT_WIDTH];
  assign w_sample = w_over ? {OUT_WIDTH{1'b1}} : fir_data[OUT_WIDTH-1:0];
  assign w_pop    = !w_empty && m_if.m_ready;
  assign w_drop   = w_strobe && w_full && !w_pop;

  fir_sfifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (rst),
    .i_push  (w_strobe),
    .i_pop   (w_pop),
    .i_data  (w_sample),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign m_if.m_data  = w_fifo_data;
  assign m_if.m_valid = !w_empty;
  assign level        = w_level;

  // A drop in the clearing cycle counts as the first event after the clear.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= 8'd0;
    end else if (w_drop) begin
      if (clr_stat) begin
        ovf_cnt <= 8'd1;
      end else if (ovf_cnt == 8'd255) begin
        ovf_cnt <= ovf_cnt;
      end else begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end else if (clr_stat) begin
      ovf_cnt <= 8'd0;
    end else begin
      ovf_cnt <= ovf_cnt;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (w_strobe && w_over) begin
      sat_flag <= 1'b1;
    end else if (clr_stat) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= sat_flag;
    end
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo with a queue scoreboard of expected delivered samples.
module tb_fir_decim_fifo;

  localparam int WARMUP = 12;
  localparam int DECIM  = 4;
  localparam int DEPTH  = 8;

  logic        CLK      = 1'b0;
  logic        rst      = 1'b1;
  logic [18:0] fir_data = 19'd0;
  logic        clr_stat = 1'b0;
  logic [3:0]  level;
  logic [7:0]  ovf_cnt;
  logic        sat_flag;

  int          errors      = 0;
  int          checks      = 0;
  int          cyc         = 0;
  bit          big_pending = 1'b0;
  logic [15:0] exp_q[$];
  int          m_ovf       = 0;
  bit          m_sat       = 1'b0;
  int          first_cyc   = 0;

  fir_decim_fifo_if m_if();

  fir_decim_fifo dut (
    .CLK      (CLK),
    .rst      (rst),
    .fir_data (fir_data),
    .m_if     (m_if),
    .level    (level),
    .ovf_cnt  (ovf_cnt),
    .sat_flag (sat_flag),
    .clr_stat (clr_stat)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_strobe(input int c);
    return (c >= WARMUP) && (((c - WARMUP) % DECIM) == (DECIM - 1));
  endfunction

  // One clock: drive fir_data, update the reference model, then check after the edge.
  task automatic tick();
    bit          strobe;
    bit          pop;
    bit          full_b;
    bit          drop;
    logic [18:0] d;
    logic [15:0] smp;
    strobe = is_strobe(cyc);
    d = 19'(cyc);
    if (big_pending && strobe) begin
      d = 19'h12345;
      big_pending = 1'b0;
    end
    fir_data = d;
    pop = (exp_q.size() != 0) && (m_if.m_ready === 1'b1);
    if (pop) check("pop_data", 32'(m_if.m_data), 32'(exp_q[0]));
    smp    = (d > 19'h0FFFF) ? 16'hFFFF : d[15:0];
    full_b = (exp_q.size() == DEPTH);
    drop   = strobe && full_b && !pop;
    if (pop) void'(exp_q.pop_front());
    if (strobe && !drop) exp_q.push_back(smp);
    if (drop) m_ovf = clr_stat ? 1 : ((m_ovf < 255) ? m_ovf + 1 : 255);
    else if (clr_stat) m_ovf = 0;
    if (strobe && (d > 19'h0FFFF)) m_sat = 1'b1;
    else if (clr_stat) m_sat = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    check("level", 32'(level), 32'(exp_q.size()));
    check("m_valid", 32'(m_if.m_valid), 32'(exp_q.size() != 0));
    check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    check("sat_flag", 32'(sat_flag), 32'(m_sat));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_m_data", 32'(m_if.m_data), 32'd0);
    exp_q.delete();
    m_ovf = 0;
    m_sat = 1'b0;
    big_pending = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic align();
    for (int k = 0; k < 2 * DECIM && !is_strobe(cyc); k++) tick();
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    @(negedge CLK);
    do_reset();

    // Warm-up: first delivered samples are 15, 19, ...
    m_if.m_ready = 1'b1;
    repeat (15) tick();
    check("warm_no_valid", 32'(m_if.m_valid), 32'd0);
    tick();
    check("warm_first", 32'(m_if.m_data), 32'd15);
    repeat (4) tick();
    check("warm_second", 32'(m_if.m_data), 32'd19);
    repeat (20) tick();

    // Clamp on a strobe, then clear the sticky flag.
    big_pending = 1'b1;
    for (int k = 0; k < 2 * DECIM && big_pending; k++) tick();
    check("clamp_data", 32'(m_if.m_data), 32'hFFFF);
    check("clamp_sat", 32'(sat_flag), 32'd1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clamp_clr", 32'(sat_flag), 32'd0);

    // Overflow: 40 strobes with no consumer.
    align();
    first_cyc = cyc;
    m_if.m_ready = 1'b0;
    repeat (40 * DECIM) tick();
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_cnt32", 32'(ovf_cnt), 32'd32);
    check("ovf_head", 32'(m_if.m_data), 32'(first_cyc));

    // Full with push and pop together on a strobe cycle.
    m_if.m_ready = 1'b1;
    tick();
    check("full_pp_level", 32'(level), 32'd8);
    check("full_pp_ovf", 32'(ovf_cnt), 32'd32);
    repeat (40) tick();

    // Reset mid-stream with five queued samples.
    align();
    m_if.m_ready = 1'b0;
    repeat (4 * DECIM + 1) tick();
    check("mid_level5", 32'(level), 32'd5);
    do_reset();
    m_if.m_ready = 1'b1;
    repeat (WARMUP + DECIM - 1) tick();
    check("mid_no_valid", 32'(m_if.m_valid), 32'd0);
    tick();
    check("mid_valid", 32'(m_if.m_valid), 32'd1);
    check("mid_data", 32'(m_if.m_data), 32'd15);

    // Drop counter saturation and clear racing a drop.
    repeat (20) tick();
    align();
    m_if.m_ready = 1'b0;
    repeat (308 * DECIM) tick();
    check("sat_ovf255", 32'(ovf_cnt), 32'd255);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clr_with_drop", 32'(ovf_cnt), 32'd1);
    m_if.m_ready = 1'b1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IN_WIDTH  19  width of filter result word
  OUT_WIDTH  16  width of delivered sample
  DECIM  4  keep one of every DECIM filter results
  DEPTH  8  output FIFO entries, power of two
  WARMUP  12  filter results discarded after reset (8 taps + pipeline fill)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK  input  1  single clock, all logic on rising edge
  rst  input  1  asynchronous active-low reset
  fir_data  input  IN_WIDTH  unsigned filter result, new word every cycle
  m_data  output  OUT_WIDTH  head-of-FIFO sample
  m_valid  output  1  FIFO non-empty
  m_ready  input  1  consumer accepts m_data this cycle
  level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
  ovf_cnt  output  8  dropped-sample count, saturating at 255
  sat_flag  output  1  sticky, a sample was clamped
  clr_stat  input  1  one-cycle pulse clearing ovf_cnt and sat_flag

Function
REQ-003 Warm-up counter SHALL count input cycles after reset; the first WARMUP fir_data words SHALL be discarded; the warm state SHALL be entered after the WARMUP-th cycle and held until reset.
REQ-004 Decimation counter SHALL run 0..DECIM-1 only while warm, starting at 0 on the first warm cycle; a sample strobe SHALL occur when the counter equals DECIM-1, then wrap to 0.
REQ-005 On strobe, fir_data SHALL be clamped: values > 2^OUT_WIDTH-1 become 2^OUT_WIDTH-1 and set sat_flag; otherwise the low OUT_WIDTH bits pass unchanged.
REQ-006 The clamped sample SHALL be written to the FIFO in the strobe cycle; first warm strobe's sample is visible on m_data with m_valid=1 one cycle later.
REQ-007 m_valid SHALL equal (level != 0); m_data SHALL be the oldest entry and SHALL hold stable while m_valid=1 and m_ready=0.
REQ-008 Pop SHALL occur on m_valid && m_ready; m_ready with m_valid=0 SHALL have no effect.
REQ-009 Push while full and no pop SHALL drop the sample, leave FIFO contents unchanged, and increment ovf_cnt (saturating at 255).
REQ-010 Push and pop in the same cycle SHALL both succeed at any level including full; level unchanged.
REQ-011 Pointers SHALL wrap modulo DEPTH; level SHALL be pointer-independent and exact.
REQ-012 clr_stat SHALL zero ovf_cnt and sat_flag next cycle; a same-cycle overflow or clamp SHALL take precedence (ovf_cnt=1 / sat_flag=1).
REQ-013 No combinational path SHALL exist from fir_data or m_ready to any output except through FIFO state.

Reset
REQ-014 Asserting rst low SHALL immediately force: m_valid=0, level=0, ovf_cnt=0, sat_flag=0, m_data=0, warm-up and decimation counters 0, pointers 0.
REQ-015 Reset mid-operation SHALL discard all queued samples and restart the full WARMUP sequence after rst release.

Structure
REQ-016 A shared package fir_pkg SHALL hold IN_WIDTH, OUT_WIDTH, DECIM, DEPTH, WARMUP defaults and the sample typedef (logic [OUT_WIDTH-1:0]).
REQ-017 The FIFO SHALL be a separate sub-module fir_sfifo (push, pop, data, full, empty, level); warm-up, decimation, clamp and statistics stay in fir_decim_fifo.

Verification
REQ-018 Warm-up: reset, fir_data=cycle index, m_ready=1 -> first m_data = 15 (index 12 + DECIM-1), then 19, 23, ...
REQ-019 Clamp: fir_data=19'h12345 on a strobe -> m_data=16'hFFFF, sat_flag=1; clr_stat pulse -> sat_flag=0.
REQ-020 Overflow: m_ready=0 after warm-up for 40 strobes -> level=8, ovf_cnt=32, m_data equals first stored sample; m_ready=1 -> eight samples in original order.
REQ-021 Full with simultaneous push/pop: level=8, m_ready=1 on a strobe cycle -> level stays 8, ovf_cnt unchanged, new sample appears last.
REQ-022 Reset mid-stream: level=5, assert rst one cycle -> m_valid=0, level=0 immediately; next sample after exactly WARMUP+DECIM cycles.
REQ-023 Saturation of ovf_cnt: 300 drops -> ovf_cnt=255; clr_stat with simultaneous drop -> ovf_cnt=1.
